fifo_wr_ctrl: RTL

Write-side pointer and flag controller for the async FIFO, running entirely in the write clock domain. It accepts write requests, produces the RAM write address and the Gray-coded write pointer that is handed to the write-to-read pointer synchronizer, and compares against the read pointer already synchronized into the write domain to generate full, almost-full, level and overflow status.

---
 rtl/fifo_wr_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side pointer, address and full/overflow controller.
// Define FIFO_WR_LEVEL_EN to build the wlevel / walmost_full logic.
module fifo_wr_ctrl #(
    parameter int ASIZE        = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic             wclr_ovf,
    input  logic [ASIZE:0]   wq2_rptr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam int DEPTH = 1 << ASIZE;

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic           wacc;
    logic           wfull_next;
    logic           ovf_next;

    assign wacc       = winc && !wfull;
    assign wbin_next  = wbin + {{ASIZE{1'b0}}, wacc};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign waddr      = wbin[ASIZE-1:0];

    // Full when the write pointer laps the read pointer by exactly one wrap.
    assign wfull_next = (wgray_next ==
                         {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

    assign ovf_next = (winc && wfull) || (woverflow && !wclr_ovf);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr      <= wgray_next;
            wfull     <= wfull_next;
            woverflow <= ovf_next;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    logic [ASIZE:0]   rbin;
    logic [ASIZE:0]   wlevel_next;
    logic [ASIZE+1:0] free_next;
    logic             afull_next;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign wlevel_next = wbin_next - rbin;
    assign free_next   = (ASIZE+2)'(DEPTH) - {1'b0, wlevel_next};
    assign afull_next  = free_next <= (ASIZE+2)'(AFULL_THRESH);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= wlevel_next;
            walmost_full <= afull_next;
        end
    end
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule
